// File: rtl/nap_eth_tx_pkt_gen.sv
// Fixed-length Ethernet frame generator feeding the TX stream of an Ethernet NAP.
// Optional error injection port enabled by defining ACX_PKT_GEN_ERR_INJ_EN.
module nap_eth_tx_pkt_gen #(
    parameter int DATA_WIDTH = 256,
    parameter int MOD_WIDTH  = 5,
    parameter int ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR = 4'hf,
    parameter int LEN_WIDTH  = 14,
    parameter int IPG_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    input  logic [31:0]           i_num_pkts,
    input  logic                  i_ready,
`ifdef ACX_PKT_GEN_ERR_INJ_EN
    input  logic                  i_err_inject,
`endif
    output logic                  o_valid,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [MOD_WIDTH-1:0]  o_mod,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [29:0]           o_flags,
    output logic [29:0]           o_timestamp,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_pkt_count
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int NBW = $clog2(NB);
    localparam int BW  = LEN_WIDTH + NBW;
    localparam int GW  = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                state, nstate;
    logic [LEN_WIDTH-1:0]  len_q, lenc, g_len, g_beat, beat_q, blast;
    logic [LEN_WIDTH:0]    lsum;
    logic [31:0]           num_q;
    logic [16:0]           seq_q, g_seq;
    logic [GW-1:0]         gap_q;
    logic [29:0]           ts_cnt;
    logic                  stop_q, err_cur, pend_eff;
    logic                  xfer, last, stop_eff, fin, gap_end;
    logic                  launch, adv, g_eop, g_err;
    logic [DATA_WIDTH-1:0] g_data;
    logic [BW-1:0]         k;

    assign o_addr   = DEST_ADDR;
    assign xfer     = o_valid & i_ready;
    assign last     = xfer & o_eop;
    assign stop_eff = stop_q | i_stop;
    assign fin      = ((num_q != 32'd0) && (o_pkt_count + 32'd1 == num_q)) || stop_eff;
    assign gap_end  = (gap_q == GW'(IPG_CYCLES - 1));
    assign lenc     = (i_pkt_len < LEN_WIDTH'(64)) ? LEN_WIDTH'(64) : i_pkt_len;

`ifdef ACX_PKT_GEN_ERR_INJ_EN
    logic err_pend;
    assign pend_eff = err_pend | i_err_inject;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) err_pend <= 1'b0;
        else         err_pend <= launch ? 1'b0 : pend_eff;
    end
`else
    assign pend_eff = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: if (i_start) nstate = S_SEND;
            S_SEND: if (last) nstate = fin ? S_DONE :
                                (IPG_CYCLES == 0) ? S_SEND : S_GAP;
            S_GAP:  if (gap_end) nstate = stop_eff ? S_DONE : S_SEND;
            S_DONE: nstate = S_IDLE;
        endcase
    end

    // Select which beat gets loaded into the output registers next.
    always_comb begin
        launch = 1'b0;
        adv    = 1'b0;
        g_seq  = seq_q;
        g_len  = len_q;
        g_beat = beat_q + LEN_WIDTH'(1);
        unique case (state)
            S_IDLE: if (i_start) begin
                launch = 1'b1;
                g_seq  = 17'd0;
                g_len  = lenc;
            end
            S_SEND: begin
                if (last && !fin && IPG_CYCLES == 0) begin
                    launch = 1'b1;
                    g_seq  = seq_q + 17'd1;
                end
                adv = xfer & ~o_eop;
            end
            S_GAP:  launch = gap_end & ~stop_eff;
            S_DONE: ;
        endcase
        if (launch) g_beat = '0;
        g_err = launch ? pend_eff : err_cur;
        lsum  = {1'b0, g_len} + (LEN_WIDTH+1)'(NB - 1);
        blast = LEN_WIDTH'(lsum >> NBW) - LEN_WIDTH'(1);
        g_eop = (g_beat == blast);
        k     = '0;
        for (int j = 0; j < NB; j++) begin
            k = {g_beat, NBW'(j)};
            g_data[j*8 +: 8] = (k < BW'(g_len)) ? (k[7:0] + g_seq[7:0]) : 8'h00;
        end
        if (launch && g_err) g_data[7:0] = ~g_data[7:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_data      <= '0;
            o_mod       <= '0;
            o_flags     <= '0;
            o_timestamp <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pkt_count <= '0;
            len_q       <= '0;
            num_q       <= '0;
            seq_q       <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            ts_cnt      <= '0;
            stop_q      <= 1'b0;
            err_cur     <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + 30'd1;
            o_busy <= (nstate == S_SEND) || (nstate == S_GAP);
            o_done <= (nstate == S_DONE);
            gap_q  <= (state == S_GAP) ? gap_q + GW'(1) : '0;
            if (state == S_IDLE && i_start) begin
                len_q       <= lenc;
                num_q       <= i_num_pkts;
                seq_q       <= '0;
                o_pkt_count <= '0;
                stop_q      <= i_stop;
            end else if (state == S_SEND || state == S_GAP) begin
                stop_q <= stop_eff;
            end
            if (last) begin
                o_pkt_count <= o_pkt_count + 32'd1;
                seq_q       <= seq_q + 17'd1;
            end
            if (launch || adv) begin
                o_valid <= 1'b1;
                o_sop   <= launch;
                o_eop   <= g_eop;
                o_data  <= g_data;
                o_mod   <= g_eop ? g_len[MOD_WIDTH-1:0] : '0;
                o_flags <= {g_seq, 10'd0, 1'b1, 1'b1, g_err};
                beat_q  <= g_beat;
            end else if (last) begin
                o_valid <= 1'b0;
                o_sop   <= 1'b0;
                o_eop   <= 1'b0;
            end
            if (launch) begin
                o_timestamp <= ts_cnt;
                err_cur     <= g_err;
            end
        end
    end
endmodule

// File: tb/tb_nap_eth_tx_pkt_gen.sv
// Randomized-handshake bench for nap_eth_tx_pkt_gen against a byte-level frame model.
// Define ACX_PKT_GEN_ERR_INJ_EN to also exercise error injection.
module tb_nap_eth_tx_pkt_gen;
    localparam int IPG = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start, i_stop, i_ready;
    logic [13:0]  i_pkt_len;
    logic [31:0]  i_num_pkts;
    logic         o_valid, o_sop, o_eop, o_busy, o_done;
    logic [255:0] o_data;
    logic [4:0]   o_mod;
    logic [3:0]   o_addr;
    logic [29:0]  o_flags, o_timestamp;
    logic [31:0]  o_pkt_count;
`ifdef ACX_PKT_GEN_ERR_INJ_EN
    logic         i_err_inject = 1'b0;
`endif

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    bit err_armed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    nap_eth_tx_pkt_gen dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_stop(i_stop),
        .i_pkt_len(i_pkt_len), .i_num_pkts(i_num_pkts), .i_ready(i_ready),
`ifdef ACX_PKT_GEN_ERR_INJ_EN
        .i_err_inject(i_err_inject),
`endif
        .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_data(o_data),
        .o_mod(o_mod), .o_addr(o_addr), .o_flags(o_flags),
        .o_timestamp(o_timestamp), .o_busy(o_busy), .o_done(o_done),
        .o_pkt_count(o_pkt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_beat(int len, int s, int b, bit e);
        logic [255:0] v = '0;
        for (int j = 0; j < 32; j++) begin
            int kk = b * 32 + j;
            if (kk < len) v[j*8 +: 8] = 8'((kk + s) % 256);
            if (e && kk == 0) v[7:0] = ~v[7:0];
        end
        return v;
    endfunction

    function automatic logic [29:0] exp_flags(int s, bit e);
        logic [31:0] sv = s;
        return {sv[16:0], 10'd0, 1'b1, 1'b1, e};
    endfunction

    // One run: start, follow every beat against the model until o_done.
    task automatic run(input int len, input int n, input int rdy_pct,
                       input int stop_pkt, input bit stop_at_start,
                       input bit poke, input int exp_cnt);
        int L, B, seq, beat, idle, cycles, prev_cyc;
        bit in_pkt, prev_stall, seen_done, cur_err;
        logic [29:0]  prev_ts;
        logic [511:0] prev_s, cur_s;
        L = (len < 64) ? 64 : len;
        B = (L + 31) / 32;
        seq = 0; beat = 0; idle = 0; cycles = 0; prev_cyc = 0;
        in_pkt = 0; prev_stall = 0; seen_done = 0; cur_err = 0;
        prev_ts = '0; prev_s = '0;
        i_pkt_len  = 14'(len);
        i_num_pkts = n;
        i_stop     = stop_at_start;
        i_start    = 1'b1;
        i_ready    = ($urandom_range(99) < rdy_pct);
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("busy_after_start", 512'(o_busy), 512'(1));
        while (!seen_done && cycles < 3000) begin
            if (o_done) begin
                chk("done_count", 512'(o_pkt_count), 512'(exp_cnt));
                chk("done_npkts", 512'(seq), 512'(exp_cnt));
                chk("done_busy", 512'(o_busy), 512'(0));
                seen_done = 1;
                break;
            end
            cur_s = {o_valid, o_sop, o_eop, o_mod, o_flags, o_timestamp, o_data};
            i_start = poke && (cycles == 5);
            if (poke && cycles == 5) i_pkt_len = 14'd300;
            if (o_valid) begin
                if (prev_stall) chk("stall_hold", cur_s, prev_s);
                if (!in_pkt) begin
                    in_pkt = 1;
                    cur_err = err_armed;
                    err_armed = 0;
                    if (seq > 0) begin
                        chk("ipg", 512'(idle), 512'(IPG));
                        chk("ts_delta", 512'(30'(o_timestamp - prev_ts)),
                            512'(30'(cyc - prev_cyc)));
                    end
                    prev_ts  = o_timestamp;
                    prev_cyc = cyc;
                end
                if (seq == stop_pkt && beat == 1) i_stop = 1'b1;
                i_ready = ($urandom_range(99) < rdy_pct);
                if (i_ready) begin
                    chk("data", 512'(o_data), 512'(exp_beat(L, seq, beat, cur_err)));
                    chk("ctl", 512'({o_sop, o_eop, o_mod, o_flags}),
                        512'({beat == 0, beat == B - 1,
                              5'((beat == B - 1) ? L % 32 : 0),
                              exp_flags(seq, cur_err)}));
                    beat++;
                    if (beat == B) begin
                        beat = 0; in_pkt = 0; idle = 0; seq++;
                    end
                end
                prev_stall = !i_ready;
                prev_s = cur_s;
            end else begin
                if (!in_pkt && seq > 0) idle++;
                prev_stall = 0;
                i_ready = ($urandom_range(99) < rdy_pct);
            end
            tick();
            cycles++;
        end
        i_start = 1'b0;
        if (!seen_done) chk("run_timeout", 512'(0), 512'(1));
        i_stop = 1'b0;
        tick();
        chk("done_pulse_end", 512'({o_done, o_busy}), 512'(0));
        chk("count_hold", 512'(o_pkt_count), 512'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1;
        i_start = 0; i_stop = 0; i_ready = 0;
        i_pkt_len = '0; i_num_pkts = '0;
        tick();
        tick();
        chk("rst_out", 512'({o_valid, o_sop, o_eop, o_busy, o_done, o_data,
                             o_mod, o_flags, o_timestamp, o_pkt_count}), 512'(0));
        chk("rst_addr", 512'(o_addr), 512'(4'hf));
        rst = 1'b0;
        tick();

        run(64, 3, 100, -1, 0, 1, 3);
        run(100, 1, 100, -1, 0, 0, 1);
        run(64, 2, 50, -1, 0, 0, 2);
        run(20, 2, 100, -1, 0, 0, 2);
        run(0, 0, 100, 5, 0, 0, 6);
        run(100, 0, 70, 3, 0, 0, 4);
        run(64, 5, 100, -1, 1, 0, 1);
        run(160, 3, 40, -1, 0, 0, 3);

`ifdef ACX_PKT_GEN_ERR_INJ_EN
        i_err_inject = 1'b1;
        tick();
        i_err_inject = 1'b0;
        err_armed = 1'b1;
        run(64, 2, 100, -1, 0, 0, 2);
`endif

        // Reset while the second beat is on the bus.
        i_pkt_len = 14'd64; i_num_pkts = 32'd3;
        i_start = 1'b1; i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        chk("rst_mid_pre", 512'({o_valid, o_sop, o_eop}), 512'(3'b101));
        rst = 1'b1;
        #1;
        chk("rst_mid_out", 512'({o_valid, o_sop, o_eop, o_busy, o_data,
                                 o_flags, o_pkt_count}), 512'(0));
        chk("rst_mid_addr", 512'(o_addr), 512'(4'hf));
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_mid_idle", 512'({o_valid, o_busy, o_done}), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
